// File: rtl/rominit_stream.sv
// ROM download manager: decodes ioctl bytes into address regions, packs them into
// little-endian words and streams the words out through a small show-ahead FIFO.
module rominit_stream #(
  parameter int                    NUM_REG    = 3,
  parameter logic [6*NUM_REG-1:0]  REG_MENU   = {6'd1, 6'd0, 6'd0},
  parameter logic [27*NUM_REG-1:0] REG_BASE   = {27'h0, 27'h1000, 27'h0},
  parameter logic [27*NUM_REG-1:0] REG_SIZE   = {27'h20000, 27'h400, 27'h1000},
  parameter int                    ADDR_W     = 17,
  parameter int                    WORD_BYTES = 1,
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic                    CLK_SYS,
  input  logic                    RESET,
  input  logic                    IOCTL_DOWNLOAD,
  input  logic [15:0]             IOCTL_INDEX,
  input  logic                    IOCTL_WR,
  input  logic [26:0]             IOCTL_ADDR,
  input  logic [7:0]              IOCTL_DOUT,
  output logic                    IOCTL_WAIT,
  output logic [NUM_REG-1:0]      ROMINIT_SEL,
  output logic [ADDR_W-1:0]       ROMINIT_ADDR,
  output logic [8*WORD_BYTES-1:0] ROMINIT_DATA,
  output logic [WORD_BYTES-1:0]   ROMINIT_BE,
  output logic                    ROMINIT_VALID,
  input  logic                    ROMINIT_READY,
  output logic                    ROMINIT_ACTIVE,
  output logic                    ROMINIT_DONE,
  output logic [26:0]             LOAD_SIZE
);

  localparam int DW    = 8 * WORD_BYTES;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(WORD_BYTES - 1);
  localparam logic [26:0]       SIZE_MAX  = 27'h7FFFFFF;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN, S_DONE} state_t;

  function automatic logic [26:0] sat_inc(input logic [26:0] v);
    return (v == SIZE_MAX) ? v : v + 27'd1;
  endfunction

  state_t              state_q, state_d;
  logic [26:0]         load_size_q, load_size_d;
  logic                wait_q, wait_d;
  logic [DW-1:0]       pack_data_q, pack_data_d;
  logic [WORD_BYTES-1:0] pack_be_q, pack_be_d;
  logic [NUM_REG-1:0]  pack_sel_q, pack_sel_d;
  logic [ADDR_W-1:0]   pack_addr_q, pack_addr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d, free_next;

  logic [DW-1:0]         mem_data_q [FIFO_DEPTH];
  logic [WORD_BYTES-1:0] mem_be_q   [FIFO_DEPTH];
  logic [NUM_REG-1:0]    mem_sel_q  [FIFO_DEPTH];
  logic [ADDR_W-1:0]     mem_addr_q [FIFO_DEPTH];

  logic                hit, accept, take, pack_busy, mismatch, push, pop, fifo_vld;
  logic [NUM_REG-1:0]  hit_sel;
  logic [ADDR_W-1:0]   rel_addr, lane_bits, word_addr;
  logic [27:0]         base, lim;
  logic                unused_idx;

  assign unused_idx = ^IOCTL_INDEX[15:6];

  // Region decode: iterate downwards so the lowest matching region wins.
  always_comb begin
    hit      = 1'b0;
    hit_sel  = '0;
    rel_addr = '0;
    base     = '0;
    lim      = '0;
    for (int i = NUM_REG - 1; i >= 0; i--) begin
      base = {1'b0, REG_BASE[27*i +: 27]};
      lim  = base + {1'b0, REG_SIZE[27*i +: 27]};
      if (IOCTL_INDEX[5:0] == REG_MENU[6*i +: 6] &&
          {1'b0, IOCTL_ADDR} >= base && {1'b0, IOCTL_ADDR} < lim) begin
        hit        = 1'b1;
        hit_sel    = '0;
        hit_sel[i] = 1'b1;
        rel_addr   = ADDR_W'(IOCTL_ADDR - REG_BASE[27*i +: 27]);
      end
    end
  end

  assign lane_bits = rel_addr & LANE_MASK;
  assign word_addr = rel_addr & ~LANE_MASK;
  assign accept    = IOCTL_DOWNLOAD & IOCTL_WR & (state_q == S_LOAD);
  assign take      = accept & hit;
  assign pack_busy = |pack_be_q;
  assign mismatch  = pack_busy && (hit_sel != pack_sel_q || word_addr != pack_addr_q);
  // A held word leaves the pack register one cycle after its top lane is written,
  // when a byte for a different word arrives, or during FLUSH.
  assign push = pack_busy &&
                (pack_be_q[WORD_BYTES-1] || (take && mismatch) || state_q == S_FLUSH);
  assign fifo_vld = (count_q != '0);
  assign pop      = fifo_vld & ROMINIT_READY;

  always_comb begin
    pack_data_d = pack_data_q;
    pack_be_d   = pack_be_q;
    pack_sel_d  = pack_sel_q;
    pack_addr_d = pack_addr_q;
    if (push || state_q == S_IDLE) pack_be_d = '0;
    if (take) begin
      if (push || !pack_busy) begin
        pack_data_d = '0;
        pack_be_d   = '0;
      end
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (lane_bits == ADDR_W'(b)) begin
          pack_data_d[8*b +: 8] = IOCTL_DOUT;
          pack_be_d[b]          = 1'b1;
        end
      end
      pack_sel_d  = hit_sel;
      pack_addr_d = word_addr;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (IOCTL_DOWNLOAD) state_d = S_LOAD;
      S_LOAD:  if (!IOCTL_DOWNLOAD) state_d = S_FLUSH;
      S_FLUSH: state_d = S_DRAIN;
      S_DRAIN: if (count_q == '0 && !pack_busy) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    load_size_d = load_size_q;
    if (state_q == S_IDLE && state_d == S_LOAD) load_size_d = '0;
    else if (accept)                            load_size_d = sat_inc(load_size_q);

    wr_ptr_d  = wr_ptr_q + PTR_W'(push);
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    free_next = CNT_W'(FIFO_DEPTH) - count_d;
    // Two spare slots cover one byte already in flight plus one forced push.
    wait_d    = (free_next <= CNT_W'(2)) &&
                (state_d == S_LOAD || state_d == S_FLUSH || state_d == S_DRAIN);
  end

  always_ff @(posedge CLK_SYS) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      load_size_q <= '0;
      wait_q      <= 1'b0;
      pack_be_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      load_size_q <= load_size_d;
      wait_q      <= wait_d;
      pack_be_q   <= pack_be_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Payload storage carries no reset; the outputs are masked while the FIFO is empty.
  always_ff @(posedge CLK_SYS) begin
    pack_data_q <= pack_data_d;
    pack_sel_q  <= pack_sel_d;
    pack_addr_q <= pack_addr_d;
    if (push) begin
      mem_data_q[wr_ptr_q] <= pack_data_q;
      mem_be_q[wr_ptr_q]   <= pack_be_q;
      mem_sel_q[wr_ptr_q]  <= pack_sel_q;
      mem_addr_q[wr_ptr_q] <= pack_addr_q;
    end
  end

  a_no_overflow: assert property (@(posedge CLK_SYS) disable iff (RESET)
    !(push && !pop && count_q == CNT_W'(FIFO_DEPTH)));

  assign IOCTL_WAIT     = wait_q;
  assign ROMINIT_VALID  = fifo_vld;
  assign ROMINIT_DATA   = fifo_vld ? mem_data_q[rd_ptr_q] : '0;
  assign ROMINIT_BE     = fifo_vld ? mem_be_q[rd_ptr_q]   : '0;
  assign ROMINIT_SEL    = fifo_vld ? mem_sel_q[rd_ptr_q]  : '0;
  assign ROMINIT_ADDR   = fifo_vld ? mem_addr_q[rd_ptr_q] : '0;
  assign ROMINIT_ACTIVE = (state_q != S_IDLE);
  assign ROMINIT_DONE   = (state_q == S_DONE);
  assign LOAD_SIZE      = load_size_q;

endmodule

// File: tb/tb_rominit_stream.sv
// Directed bench for rominit_stream: a byte-wide instance (A) and a 16-bit-word instance (B).
module tb_rominit_stream;

  typedef struct packed {
    logic [2:0]  sel;
    logic [16:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
  } word_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic        a_download, a_wr, a_wait, a_valid, a_ready, a_active, a_done;
  logic [15:0] a_index;
  logic [26:0] a_addr, a_size;
  logic [7:0]  a_dout, a_data;
  logic [2:0]  a_sel;
  logic [16:0] a_addr_o;
  logic [0:0]  a_be;

  logic        b_download, b_wr, b_wait, b_valid, b_ready, b_active, b_done;
  logic [15:0] b_index;
  logic [26:0] b_addr, b_size;
  logic [7:0]  b_dout;
  logic [15:0] b_data;
  logic [2:0]  b_sel;
  logic [16:0] b_addr_o;
  logic [1:0]  b_be;

  rominit_stream dut_a (
    .CLK_SYS(clk), .RESET(rst),
    .IOCTL_DOWNLOAD(a_download), .IOCTL_INDEX(a_index), .IOCTL_WR(a_wr),
    .IOCTL_ADDR(a_addr), .IOCTL_DOUT(a_dout), .IOCTL_WAIT(a_wait),
    .ROMINIT_SEL(a_sel), .ROMINIT_ADDR(a_addr_o), .ROMINIT_DATA(a_data),
    .ROMINIT_BE(a_be), .ROMINIT_VALID(a_valid), .ROMINIT_READY(a_ready),
    .ROMINIT_ACTIVE(a_active), .ROMINIT_DONE(a_done), .LOAD_SIZE(a_size)
  );

  rominit_stream #(.WORD_BYTES(2)) dut_b (
    .CLK_SYS(clk), .RESET(rst),
    .IOCTL_DOWNLOAD(b_download), .IOCTL_INDEX(b_index), .IOCTL_WR(b_wr),
    .IOCTL_ADDR(b_addr), .IOCTL_DOUT(b_dout), .IOCTL_WAIT(b_wait),
    .ROMINIT_SEL(b_sel), .ROMINIT_ADDR(b_addr_o), .ROMINIT_DATA(b_data),
    .ROMINIT_BE(b_be), .ROMINIT_VALID(b_valid), .ROMINIT_READY(b_ready),
    .ROMINIT_ACTIVE(b_active), .ROMINIT_DONE(b_done), .LOAD_SIZE(b_size)
  );

  word_t a_q[$];
  word_t b_q[$];
  int a_done_cnt = 0;
  int b_done_cnt = 0;
  int a_sent = 0;

  // Transfers are recorded on the falling edge; inputs only change just after rising edges.
  always @(negedge clk) begin
    if (a_valid && a_ready) a_q.push_back({a_sel, a_addr_o, {8'h00, a_data}, {1'b0, a_be}});
    if (b_valid && b_ready) b_q.push_back({b_sel, b_addr_o, b_data, b_be});
    if (a_done) a_done_cnt++;
    if (b_done) b_done_cnt++;
  end

  task automatic a_write(input logic [26:0] addr, input logic [7:0] d);
    int guard = 0;
    while (a_wait && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (guard >= 1000) begin
      fails++;
      $display("FAIL a_wait_timeout: IOCTL_WAIT=%0b after %0d cycles, required 0", a_wait, guard);
    end
    a_addr = addr; a_dout = d; a_wr = 1'b1;
    @(posedge clk); #1;
    a_wr = 1'b0;
    a_sent++;
  endtask

  task automatic b_write(input logic [26:0] addr, input logic [7:0] d);
    int guard = 0;
    while (b_wait && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (guard >= 1000) begin
      fails++;
      $display("FAIL b_wait_timeout: IOCTL_WAIT=%0b after %0d cycles, required 0", b_wait, guard);
    end
    b_addr = addr; b_dout = d; b_wr = 1'b1;
    @(posedge clk); #1;
    b_wr = 1'b0;
  endtask

  task automatic a_finish();
    a_download = 1'b0;
    for (int c = 0; c < 300 && a_active; c++) @(negedge clk);
    checks++;
    if (a_active !== 1'b0) begin
      fails++;
      $display("FAIL a_drain_timeout: ROMINIT_ACTIVE=%0b, required 0", a_active);
    end
    @(posedge clk); #1;
  endtask

  task automatic b_finish();
    b_download = 1'b0;
    for (int c = 0; c < 300 && b_active; c++) @(negedge clk);
    checks++;
    if (b_active !== 1'b0) begin
      fails++;
      $display("FAIL b_drain_timeout: ROMINIT_ACTIVE=%0b, required 0", b_active);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_a_zero(input string tag);
    logic [63:0] got;
    got = {a_wait, a_valid, a_sel, a_addr_o, a_data, a_be, a_active, a_done, a_size};
    checks++;
    if (got !== 64'h0) begin
      fails++;
      $display("FAIL %s: wait=%0b valid=%0b sel=%b addr=%h data=%h be=%b active=%0b done=%0b size=%h, required all 0",
               tag, a_wait, a_valid, a_sel, a_addr_o, a_data, a_be, a_active, a_done, a_size);
    end
  endtask

  task automatic test_reset();
    check_a_zero("reset_a_outputs");
    checks++;
    if ({b_valid, b_data, b_be, b_sel, b_addr_o, b_wait, b_active, b_done, b_size} !== '0) begin
      fails++;
      $display("FAIL reset_b_outputs: valid=%0b data=%h be=%b size=%h, required all 0",
               b_valid, b_data, b_be, b_size);
    end
  endtask

  task automatic test_region_stream();
    int    bad = -1;
    word_t got_w, exp_w;
    a_q.delete(); a_done_cnt = 0; a_ready = 1'b1; a_index = 16'd0; a_download = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (a_active !== 1'b1) begin
      fails++;
      $display("FAIL t1_active: ROMINIT_ACTIVE=%0b, required 1", a_active);
    end
    for (int i = 0; i < 'h1400; i++) a_write(27'(i), 8'(i));
    a_finish();
    checks++;
    if (a_q.size() != 5120) begin
      fails++;
      $display("FAIL t1_word_count: got %0d words, required 5120", a_q.size());
    end
    for (int i = 0; i < a_q.size() && i < 5120; i++) begin
      if (i < 4096) exp_w = {3'b001, 17'(i), 16'(i % 256), 2'b01};
      else          exp_w = {3'b010, 17'(i - 4096), 16'(i % 256), 2'b01};
      if (bad < 0 && a_q[i] !== exp_w) begin
        bad = i; got_w = a_q[i];
        $display("t1 first divergence at word %0d: got %h required %h", i, got_w, exp_w);
      end
    end
    checks++;
    if (bad != -1) begin
      fails++;
      $display("FAIL t1_words: first wrong word index %0d, required none", bad);
    end
    checks++;
    if (a_done_cnt != 1) begin
      fails++;
      $display("FAIL t1_done_pulses: got %0d, required 1", a_done_cnt);
    end
    checks++;
    if (a_size !== 27'h1400) begin
      fails++;
      $display("FAIL t1_load_size: got %h, required 1400", a_size);
    end
  endtask

  task automatic test_pack_flush();
    b_q.delete(); b_done_cnt = 0; b_ready = 1'b1; b_index = 16'd1; b_download = 1'b1;
    @(posedge clk); #1;
    b_write(27'd0, 8'h11);
    b_write(27'd1, 8'h22);
    checks++;
    if (b_valid !== 1'b0) begin
      fails++;
      $display("FAIL t2_latency_n1: VALID=%0b one cycle after completing byte, required 0", b_valid);
    end
    b_write(27'd2, 8'h33);
    checks++;
    if (b_valid !== 1'b1 || b_data !== 16'h2211) begin
      fails++;
      $display("FAIL t2_latency_n2: VALID=%0b data=%h two cycles after, required 1 / 2211", b_valid, b_data);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (b_q.size() != 1) begin
      fails++;
      $display("FAIL t2_partial_held: got %0d words before flush, required 1", b_q.size());
    end
    b_finish();
    checks++;
    if (b_q.size() != 2) begin
      fails++;
      $display("FAIL t2_word_count: got %0d, required 2", b_q.size());
    end else begin
      checks++;
      if (b_q[0] !== {3'b100, 17'd0, 16'h2211, 2'b11}) begin
        fails++;
        $display("FAIL t2_word0: got %h, required %h", b_q[0], {3'b100, 17'd0, 16'h2211, 2'b11});
      end
      checks++;
      if (b_q[1] !== {3'b100, 17'd2, 16'h0033, 2'b01}) begin
        fails++;
        $display("FAIL t2_word1: got %h, required %h", b_q[1], {3'b100, 17'd2, 16'h0033, 2'b01});
      end
    end
    checks++;
    if (b_done_cnt != 1) begin
      fails++;
      $display("FAIL t2_done_pulses: got %0d, required 1", b_done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int bad = -1;
    int unstable = 0;
    int sent_at_wait = -1;
    a_q.delete(); a_done_cnt = 0; a_sent = 0; a_ready = 1'b0; a_index = 16'd0; a_download = 1'b1;
    @(posedge clk); #1;
    fork
      begin
        for (int k = 0; k < 20; k++) a_write(27'(k), 8'(k + 'h40));
      end
      begin
        for (int c = 0; c < 50; c++) begin
          @(negedge clk);
          if (a_wait && sent_at_wait < 0) sent_at_wait = a_sent;
          if (c >= 5 && !(a_valid === 1'b1 && a_data === 8'h40 && a_addr_o === 17'd0 && a_sel === 3'b001))
            unstable++;
        end
        a_ready = 1'b1;
      end
    join
    checks++;
    if (sent_at_wait != 3) begin
      fails++;
      $display("FAIL t3_wait_rise: bytes accepted when WAIT rose %0d, required 3", sent_at_wait);
    end
    checks++;
    if (unstable != 0) begin
      fails++;
      $display("FAIL t3_stall_stable: %0d stalled cycles with moving head, required 0", unstable);
    end
    a_finish();
    checks++;
    if (a_q.size() != 20) begin
      fails++;
      $display("FAIL t3_word_count: got %0d, required 20", a_q.size());
    end
    for (int k = 0; k < a_q.size() && k < 20; k++)
      if (bad < 0 && a_q[k] !== {3'b001, 17'(k), 16'(k + 'h40), 2'b01}) bad = k;
    checks++;
    if (bad != -1) begin
      fails++;
      $display("FAIL t3_order: first wrong word index %0d, required none", bad);
    end
  endtask

  task automatic test_unmatched();
    a_q.delete(); a_done_cnt = 0; a_ready = 1'b1; a_index = 16'd0; a_download = 1'b1;
    @(posedge clk); #1;
    a_write(27'h2000, 8'h5A);
    a_finish();
    checks++;
    if (a_q.size() != 0) begin
      fails++;
      $display("FAIL t4_no_word: got %0d words, required 0", a_q.size());
    end
    checks++;
    if (a_size !== 27'd1) begin
      fails++;
      $display("FAIL t4_load_size: got %h, required 1", a_size);
    end
    checks++;
    if (a_done_cnt != 1) begin
      fails++;
      $display("FAIL t4_done_pulses: got %0d, required 1", a_done_cnt);
    end
  endtask

  task automatic test_word_change();
    b_q.delete(); b_done_cnt = 0; b_ready = 1'b1; b_index = 16'd1; b_download = 1'b1;
    @(posedge clk); #1;
    b_write(27'd0, 8'hA1);
    b_write(27'd5, 8'hB2);
    b_finish();
    checks++;
    if (b_q.size() != 2) begin
      fails++;
      $display("FAIL t5_word_count: got %0d, required 2", b_q.size());
    end else begin
      checks++;
      if (b_q[0] !== {3'b100, 17'd0, 16'h00A1, 2'b01}) begin
        fails++;
        $display("FAIL t5_word0: got %h, required %h", b_q[0], {3'b100, 17'd0, 16'h00A1, 2'b01});
      end
      checks++;
      if (b_q[1] !== {3'b100, 17'd4, 16'hB200, 2'b10}) begin
        fails++;
        $display("FAIL t5_word1: got %h, required %h", b_q[1], {3'b100, 17'd4, 16'hB200, 2'b10});
      end
    end
  endtask

  task automatic test_reset_mid();
    a_q.delete(); a_done_cnt = 0; a_ready = 1'b0; a_index = 16'd0; a_download = 1'b1;
    @(posedge clk); #1;
    a_write(27'd0, 8'hC0);
    a_write(27'd1, 8'hC1);
    a_write(27'd2, 8'hC2);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (a_valid !== 1'b1 || a_wait !== 1'b1) begin
      fails++;
      $display("FAIL t6_precondition: VALID=%0b WAIT=%0b, required 1 / 1", a_valid, a_wait);
    end
    a_addr = 27'd3; a_dout = 8'hC3; a_wr = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    check_a_zero("t6_reset_outputs");
    rst = 1'b0; a_wr = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (a_active !== 1'b1 || a_size !== 27'd0) begin
      fails++;
      $display("FAIL t6_resume: ACTIVE=%0b LOAD_SIZE=%h, required 1 / 0", a_active, a_size);
    end
    a_ready = 1'b1;
    a_write(27'h10, 8'h77);
    a_write(27'h11, 8'h88);
    a_finish();
    checks++;
    if (a_size !== 27'd2) begin
      fails++;
      $display("FAIL t6_load_size: got %h, required 2", a_size);
    end
    checks++;
    if (a_q.size() != 2) begin
      fails++;
      $display("FAIL t6_word_count: got %0d, required 2", a_q.size());
    end else begin
      checks++;
      if (a_q[0] !== {3'b001, 17'h10, 16'h0077, 2'b01} || a_q[1] !== {3'b001, 17'h11, 16'h0088, 2'b01}) begin
        fails++;
        $display("FAIL t6_words: got %h %h, required %h %h", a_q[0], a_q[1],
                 {3'b001, 17'h10, 16'h0077, 2'b01}, {3'b001, 17'h11, 16'h0088, 2'b01});
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    a_download = 1'b0; a_wr = 1'b0; a_index = '0; a_addr = '0; a_dout = '0; a_ready = 1'b0;
    b_download = 1'b0; b_wr = 1'b0; b_index = '0; b_addr = '0; b_dout = '0; b_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_region_stream();
    test_pack_flush();
    test_back_to_back();
    test_unmatched();
    test_word_change();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule

// File: doc/rominit_stream.md
# rominit_stream

Parametrised ROM download manager for the HPS ioctl path. It decodes each ioctl byte into one of `NUM_REG` address regions and packs bytes into `WORD_BYTES`-wide words. Words are buffered in a small FIFO and presented to memory through a valid/ready handshake, with `IOCTL_WAIT` back-pressure. It sits between the ioctl bus and the boot, character and cartridge ROM stores, and reports completion and download size.

## Interface
- `NUM_REG`, default 3: number of decoded regions.
- `REG_MENU`, default {6'd1,6'd0,6'd0}: packed `IOCTL_INDEX[5:0]` value per region; region 0 is the LSB slice.
- `REG_BASE`, default {27'h0,27'h1000,27'h0}: packed ioctl byte base per region.
- `REG_SIZE`, default {27'h20000,27'h400,27'h1000}: packed byte size per region (boot 4 KiB, chr 1 KiB, cart 128 KiB).
- `ADDR_W`, default 17: width of the region-relative byte address.
- `WORD_BYTES`, default 1: bytes per output word, 1, 2 or 4; packing is little-endian.
- `FIFO_DEPTH`, default 4: output FIFO depth, power of two, at least 4.

Ports:
- `CLK_SYS` in 1: system clock.
- `RESET` in 1: synchronous, active-high reset.
- `IOCTL_DOWNLOAD` in 1; `IOCTL_INDEX` in 16; `IOCTL_WR` in 1; `IOCTL_ADDR` in 27; `IOCTL_DOUT` in 8: ioctl download bus.
- `IOCTL_WAIT` out 1: back-pressure to the HPS.
- `ROMINIT_SEL` out `NUM_REG`: one-hot region of the head word.
- `ROMINIT_ADDR` out `ADDR_W`: region-relative byte address of the head word, aligned to `WORD_BYTES`.
- `ROMINIT_DATA` out 8*`WORD_BYTES`: head word.
- `ROMINIT_BE` out `WORD_BYTES`: byte enables of the head word.
- `ROMINIT_VALID` out 1 / `ROMINIT_READY` in 1: output handshake.
- `ROMINIT_ACTIVE` out 1: high in any state other than IDLE.
- `ROMINIT_DONE` out 1: one-cycle pulse when a download has fully drained.
- `LOAD_SIZE` out 27: count of bytes accepted in the last download.

## Operation
- An ioctl byte is accepted when `IOCTL_DOWNLOAD & IOCTL_WR & state==LOAD`. The HPS holds `IOCTL_WR` off while `IOCTL_WAIT` is high.
- Region match: `IOCTL_INDEX[5:0]==REG_MENU[i]` and `REG_BASE[i] <= IOCTL_ADDR < REG_BASE[i]+REG_SIZE[i]`. The lowest matching i wins.
- Relative address is `IOCTL_ADDR - REG_BASE[i]`, truncated to `ADDR_W`.
- Unmatched bytes are dropped but still counted in `LOAD_SIZE`.
- Pack register fields: data, byte-enables, region, word address. A byte goes into lane `rel[log2(WORD_BYTES)-1:0]` and sets that lane's BE.
- The pack register is pushed to the FIFO:
  - when the written lane is `WORD_BYTES-1`; or
  - before a byte whose region or word address differs from the held word. In this case the old word is pushed and the new byte starts a fresh word in the same cycle; or
  - in FLUSH, if any BE is set.
- Lanes that were never written carry data 0 and BE 0.
- FIFO: show-ahead. The head drives the `ROMINIT_*` outputs, and it pops on `VALID & READY`.
- FSM:
  - IDLE → LOAD when `IOCTL_DOWNLOAD` is high (level-sensitive, so a download resumes after a reset). On entry: `LOAD_SIZE` clears and the pack register clears.
  - LOAD → FLUSH when `IOCTL_DOWNLOAD` is low.
  - FLUSH → DRAIN after one cycle; any partial word is pushed during FLUSH.
  - DRAIN → DONE when the FIFO is empty and no push is pending.
  - DONE → IDLE after one cycle. `ROMINIT_DONE` is high only in DONE.
- `LOAD_SIZE` increments by 1 per accepted byte and saturates at 27'h7FFFFFF. It holds its value in IDLE.

## Timing
- Reset values: `IOCTL_WAIT`=0, `ROMINIT_VALID`=0, `ROMINIT_SEL`=0, `ROMINIT_ADDR`=0, `ROMINIT_DATA`=0, `ROMINIT_BE`=0, `ROMINIT_ACTIVE`=0, `ROMINIT_DONE`=0, `LOAD_SIZE`=0.
- Reset also empties the FIFO, clears the pack register and puts the FSM in IDLE. Reset mid-download discards buffered data and takes priority over any write in the same cycle.
- Latency: byte completing a word accepted in cycle N → FIFO write at the edge ending N+1 → `ROMINIT_VALID` high in N+2.
- Throughput with `READY` held high: one word per cycle.
- `IOCTL_WAIT` is registered. It is high when FIFO free slots ≤ 2, counting a same-cycle push and pop. This margin absorbs one in-flight byte plus one forced push.
- The FIFO never overflows; an overflowing push is a design error, flagged by an assertion.
- Simultaneous push and pop on a full FIFO is legal.
- When `READY` is low, the head and `VALID` hold stable.
- `IOCTL_WAIT` is low in IDLE and DONE.

## Test plan
- Defaults, index 0: write 0x1400 bytes with data = addr[7:0]. Required: 4096 words with `SEL`=3'b001 and addr 0..0xFFF, then 1024 words with `SEL`=3'b010 and addr 0..0x3FF. `DONE` pulses once; `LOAD_SIZE`=0x1400.
- `WORD_BYTES`=2, index 1: bytes 0x11,0x22,0x33 at addr 0..2. Required: word 0x2211 at addr 0 with BE 2'b11, then word 0x0033 at addr 2 with BE 2'b01, emitted in FLUSH. `SEL`=3'b100.
- `ROMINIT_READY` held low for 50 cycles during a back-to-back stream. Required: `IOCTL_WAIT` rises with 2 slots free, no words are lost or reordered, and `VALID`/head stay stable while stalled.
- Index 0, address 0x2000: required no output word, `LOAD_SIZE`=1, `DONE` pulses.
- `WORD_BYTES`=2, writes at addr 0 then addr 5. Required: word at addr 0 with BE 2'b01, then word at addr 4 with BE 2'b10.
- `RESET` asserted mid-download with the FIFO non-empty. Required: all outputs reach their reset values on the next edge. Loading then resumes while `IOCTL_DOWNLOAD` is still high, and `LOAD_SIZE` counts only bytes written after the reset.
